// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver with glitch filter and scancode decoding.
//   Synchronises and de-glitches the raw PS/2 clock, receives 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop) on filtered falling edges, and
//   folds E0/F0 prefixes into ext/rel flags attached to the next scancode.
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   ps2_clk, ps2_data raw PS/2 lines, asynchronous to clk
//   code              last completed scancode (held between strobes)
//   code_valid        one-cycle strobe: code/ext/rel updated
//   ext, rel          scancode was preceded by E0 / F0
//   err               one-cycle strobe: frame rejected or timed out
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 16384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       ext,
    output logic       rel,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_d, fall;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] to_cnt;
    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          par, par_nxt;
    logic          frame_end, frame_ok, tmo;
    logic          pend_ext, pend_rel;

    // Two-flop synchronisers, idle-high like the bus itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1; clk_s2 <= 1'b1;
            dat_s1 <= 1'b1; dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk; clk_s2 <= clk_s1;
            dat_s1 <= ps2_data; dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing cycle;
    // any shorter excursion restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            par     <= par_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        par_nxt   = par;
        frame_end = 1'b0;
        frame_ok  = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: if (fall && !dat_s2) begin
                state_nxt = DATA;
                bit_nxt   = 3'd0;
            end
            DATA: if (fall) begin
                sh_nxt  = {dat_s2, shreg[7:1]};
                bit_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: if (fall) begin
                par_nxt   = dat_s2;
                state_nxt = STOP;
            end
            STOP: if (fall) begin
                frame_end = 1'b1;
                frame_ok  = (^{shreg, par}) & dat_s2;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A real edge in the same cycle wins over the timeout
        if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT)) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt <= '0;
        else if (fall || state == IDLE) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
    end

    // Strobes are registered, so they land the cycle after the stop edge.
    // err and code_valid come from exclusive branches and cannot overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            ext        <= 1'b0;
            rel        <= 1'b0;
            err        <= 1'b0;
            pend_ext   <= 1'b0;
            pend_rel   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            err        <= 1'b0;
            if (tmo || (frame_end && !frame_ok)) begin
                err      <= 1'b1;
                pend_ext <= 1'b0;
                pend_rel <= 1'b0;
            end else if (frame_end) begin
                if (shreg == 8'hE0) begin
                    pend_ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    pend_rel <= 1'b1;
                end else begin
                    code       <= shreg;
                    ext        <= pend_ext;
                    rel        <= pend_rel;
                    code_valid <= 1'b1;
                    pend_ext   <= 1'b0;
                    pend_rel   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;
    localparam int FLT  = 4;
    localparam int TMO  = 200;
    localparam int HALF = 16;
    localparam int GAP  = 40;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [7:0] code;
    logic       code_valid, ext, rel, err;

    ps2_rx #(.FILTER_LEN(FLT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .code_valid(code_valid), .ext(ext), .rel(rel), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int n_valid = 0, n_err = 0, n_both = 0, n_long = 0, last_evt_cyc = 0;
    logic cv_d = 1'b0, err_d = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid) begin n_valid++; last_evt_cyc = cyc; end
            if (err)        begin n_err++;   last_evt_cyc = cyc; end
            if (code_valid && err) n_both++;
            if ((code_valid && cv_d) || (err && err_d)) n_long++;
            cv_d  = code_valid;
            err_d = err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: scancode protocol state at frame granularity
    int         exp_v = 0, exp_e = 0;
    logic [7:0] exp_code = 8'h00;
    logic       exp_ext = 1'b0, exp_rel = 1'b0, p_ext = 1'b0, p_rel = 1'b0;
    int         stop_fall_cyc = 0;

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FLT - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 8 - (FLT - 2)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit pok, input bit sok);
        logic p;
        p = pok ? ~(^d) : (^d);
        return {sok, p, d, 1'b0};
    endfunction

    task automatic model_check(input logic [7:0] d, input bit pok, input bit sok, input string tag);
        bit ev;
        ev = 1'b1;
        if (!(pok && sok)) begin
            exp_e++; p_ext = 0; p_rel = 0;
        end else if (d == 8'hE0) begin
            p_ext = 1; ev = 0;
        end else if (d == 8'hF0) begin
            p_rel = 1; ev = 0;
        end else begin
            exp_v++; exp_code = d; exp_ext = p_ext; exp_rel = p_rel;
            p_ext = 0; p_rel = 0;
        end
        check({tag, ".nvalid"}, n_valid, exp_v);
        check({tag, ".nerr"}, n_err, exp_e);
        check({tag, ".code"}, {24'd0, code}, {24'd0, exp_code});
        check({tag, ".ext"}, {31'd0, ext}, {31'd0, exp_ext});
        check({tag, ".rel"}, {31'd0, rel}, {31'd0, exp_rel});
        if (ev) check({tag, ".lat"}, last_evt_cyc - stop_fall_cyc, 3 + FLT);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pok, input bit sok,
                              input bit glitch, input string tag);
        logic [10:0] f;
        f = mk_frame(d, pok, sok);
        for (int i = 0; i < 11; i++) send_bit(f[i], glitch);
        repeat (GAP) @(negedge clk);
        model_check(d, pok, sok, tag);
    endtask

    initial begin
        logic [10:0] f;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.code", {24'd0, code}, 32'h0);
        check("rst.cv", {31'd0, code_valid}, 32'h0);
        check("rst.err", {31'd0, err}, 32'h0);
        check("rst.extrel", {30'd0, ext, rel}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'h1C, 1, 1, 0, "basic");
        send_frame(8'hE0, 1, 1, 0, "pfx_e0");
        send_frame(8'hF0, 1, 1, 0, "pfx_f0");
        send_frame(8'h75, 1, 1, 0, "ext_rel");
        send_frame(8'h75, 1, 1, 0, "plain75");
        send_frame(8'h1C, 0, 1, 0, "bad_par");
        send_frame(8'h1C, 1, 0, 0, "bad_stop");

        // Prefix followed by a truncated frame that must time out
        send_frame(8'hF0, 1, 1, 0, "to_f0");
        f = mk_frame(8'h1C, 1, 1);
        for (int i = 0; i < 5; i++) send_bit(f[i], 0);
        repeat (TMO + 100) @(negedge clk);
        exp_e++; p_ext = 0; p_rel = 0;
        check("tmo.nerr", n_err, exp_e);
        check("tmo.nvalid", n_valid, exp_v);
        send_frame(8'h1C, 1, 1, 0, "after_tmo");

        send_frame(8'h29, 1, 1, 1, "glitch");

        // Reset in the middle of a frame, with a pending prefix
        send_frame(8'hE0, 1, 1, 0, "pre_rst");
        f = mk_frame(8'h33, 1, 1);
        for (int i = 0; i < 6; i++) send_bit(f[i], 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.code", {24'd0, code}, 32'h0);
        check("midrst.cv", {31'd0, code_valid}, 32'h0);
        rst_n = 1'b1;
        p_ext = 0; p_rel = 0; exp_code = 8'h00; exp_ext = 0; exp_rel = 0;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1, 1, 0, "post_rst");

        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            int r;
            bit pok, sok;
            r   = $urandom_range(0, 5);
            d   = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            pok = ($urandom_range(0, 7) != 0);
            sok = ($urandom_range(0, 7) != 0);
            send_frame(d, pok, sok, bit'($urandom_range(0, 1)), "rand");
        end

        check("no_overlap", n_both, 0);
        check("one_cycle", n_long, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
